// File: rtl/imm_extend_stage_pkg.sv
// Shared definitions for the immediate-extension pipeline stage:
// extension mode encodings and skid-FIFO geometry.
package imm_extend_stage_pkg;

  localparam int unsigned MODE_W     = 3;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SEXT   = 3'd0,
    MODE_ZEXT   = 3'd1,
    MODE_UPPER  = 3'd2,
    MODE_BRANCH = 3'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_extend_stage_core.sv
// Combinational immediate extension: sign/zero extend, upper placement and
// branch-offset scaling; illegal modes fall back to sign extension with err.
module imm_ext_core
  import imm_extend_stage_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext,
  output logic              err
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;

  assign sext   = {{PAD_W{imm[IN_W-1]}}, imm};
  assign zext   = {{PAD_W{1'b0}}, imm};
  assign upper  = {imm, {PAD_W{1'b0}}};
  assign branch = {sext[OUT_W-3:0], 2'b00};

  always_comb begin
    ext = sext;
    err = 1'b0;
    case (mode)
      MODE_SEXT:   ext = sext;
      MODE_ZEXT:   ext = zext;
      MODE_UPPER:  ext = upper;
      MODE_BRANCH: ext = branch;
      default:     err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Immediate-extension pipeline stage: extends at the input and buffers the
// result, tag and error flag in a 2-entry skid FIFO with registered outputs.
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_extend_stage: OUT_W must be at least IN_W+2");
  end

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t     mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  entry_t           in_entry;
  logic [OUT_W-1:0] ext_imm;
  logic             ext_err;

  logic       accept;
  logic       deliver;
  logic       wr_ptr_next;
  logic       rd_ptr_next;
  logic [1:0] count_next;
  entry_t     head_next;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .imm (in_imm),
    .mode(in_mode),
    .ext (ext_imm),
    .err (ext_err)
  );

  assign in_entry = '{imm: ext_imm, tag: in_tag, err: ext_err};

  // The output registers are preloaded with the entry that becomes the head
  // after this edge; it bypasses from the input when that slot is being written.
  always_comb begin
    accept      = in_valid && in_ready && !flush;
    deliver     = out_valid && out_ready && !flush;
    wr_ptr_next = wr_ptr ^ accept;
    rd_ptr_next = rd_ptr ^ deliver;
    count_next  = count + {1'b0, accept} - {1'b0, deliver};
    head_next   = mem[rd_ptr_next];
    if (accept && (rd_ptr_next == wr_ptr)) begin
      head_next = in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_entry;
      end
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      in_ready  <= (count_next != 2'd2);
      if (count_next != '0) begin
        out_imm <= head_next.imm;
        out_tag <= head_next.tag;
        out_err <= head_next.err;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed and scoreboarded checks for imm_extend_stage (16 -> 32 bit, 5-bit tag).
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic        out_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        err;
  } beat_t;

  imm_extend_stage #(
    .IN_W (16),
    .OUT_W(32),
    .TAG_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t model(input logic [15:0] imm, input logic [2:0] mode,
                                  input logic [4:0] tag);
    logic [31:0] s;
    beat_t b;
    s = 32'($signed(imm));
    b.tag = tag;
    b.err = 1'b0;
    case (mode)
      3'd0:    b.imm = s;
      3'd1:    b.imm = {16'h0000, imm};
      3'd2:    b.imm = {imm, 16'h0000};
      3'd3:    b.imm = s << 2;
      default: begin b.imm = s; b.err = 1'b1; end
    endcase
    return b;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_tests++; if (out_imm !== 32'h0 || out_tag !== 5'h0 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got imm=%h tag=%h err=%b expected all 0", out_imm, out_tag, out_err); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 0", in_ready); end
    step();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_edge_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_modes;
    logic [31:0] exp_imm [4];
    exp_imm[0] = 32'hFFFF8004; exp_imm[1] = 32'h00008004;
    exp_imm[2] = 32'h80040000; exp_imm[3] = 32'hFFFE0010;
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1; in_imm = 16'h8004; in_mode = 3'(m); in_tag = 5'(m + 1);
      step();
      n_tests++; if (out_valid !== 1'b1 || out_imm !== exp_imm[m] || out_err !== 1'b0 || out_tag !== 5'(m + 1)) begin
        n_fail++; $display("FAIL mode_%0d: got v=%b imm=%h err=%b tag=%0d expected v=1 imm=%h err=0 tag=%0d",
                           m, out_valid, out_imm, out_err, out_tag, exp_imm[m], m + 1); end
    end
    in_valid = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b0 || out_imm !== 32'hFFFE0010 || out_tag !== 5'd4) begin
      n_fail++; $display("FAIL empty_hold: got v=%b imm=%h tag=%0d expected v=0 imm=fffe0010 tag=4", out_valid, out_imm, out_tag); end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 3'd5; in_tag = 5'd7;
    step();
    n_tests++; if (out_valid !== 1'b1 || out_imm !== 32'h00000001 || out_err !== 1'b1 || out_tag !== 5'd7) begin
      n_fail++; $display("FAIL illegal_mode5: got v=%b imm=%h err=%b tag=%0d expected v=1 imm=00000001 err=1 tag=7",
                         out_valid, out_imm, out_err, out_tag); end
    in_imm = 16'hFFFF; in_mode = 3'd7; in_tag = 5'd3;
    step();
    n_tests++; if (out_imm !== 32'hFFFFFFFF || out_err !== 1'b1 || out_tag !== 5'd3) begin
      n_fail++; $display("FAIL illegal_mode7: got imm=%h err=%b tag=%0d expected imm=ffffffff err=1 tag=3", out_imm, out_err, out_tag); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd1;
    in_imm = 16'd1; in_tag = 5'd1;
    step();
    n_tests++; if (out_valid !== 1'b1 || out_tag !== 5'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_one_held: got v=%b tag=%0d rdy=%b expected v=1 tag=1 rdy=1", out_valid, out_tag, in_ready); end
    in_imm = 16'd2; in_tag = 5'd2;
    step();
    n_tests++; if (in_ready !== 1'b0 || out_tag !== 5'd1) begin
      n_fail++; $display("FAIL bp_full: got rdy=%b tag=%0d expected rdy=0 tag=1", in_ready, out_tag); end
    in_imm = 16'd3; in_tag = 5'd3;
    step();
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_imm !== 32'd1) begin
      n_fail++; $display("FAIL bp_stall_stable: got rdy=%b v=%b tag=%0d imm=%h expected rdy=0 v=1 tag=1 imm=1",
                         in_ready, out_valid, out_tag, out_imm); end
    out_ready = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b1 || out_tag !== 5'd2 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_first: got v=%b tag=%0d rdy=%b expected v=1 tag=2 rdy=1", out_valid, out_tag, in_ready); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_imm !== 32'd3) begin
      n_fail++; $display("FAIL bp_third: got v=%b tag=%0d imm=%h expected v=1 tag=3 imm=3", out_valid, out_tag, out_imm); end
    in_valid = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd1;
    in_imm = 16'd4; in_tag = 5'd4; step();
    in_imm = 16'd5; in_tag = 5'd5; step();
    n_tests++; if (in_ready !== 1'b0 || out_tag !== 5'd4) begin
      n_fail++; $display("FAIL flush_prefill: got rdy=%b tag=%0d expected rdy=0 tag=4", in_ready, out_tag); end
    flush = 1'b1; in_imm = 16'd9; in_tag = 5'd9; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_tag9 cyc%0d: got v=%b tag=%0d expected v=0", i, out_valid, out_tag); end
    end
    // flush while one entry is held and in_ready=1: the offered beat must still drop
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'd11; in_tag = 5'd11;
    step();
    flush = 1'b1; in_imm = 16'd12; in_tag = 5'd12;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one_held: got v=%b tag=%0d expected v=0", out_valid, out_tag); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_offered: got v=%b tag=%0d expected v=0", out_valid, out_tag); end
    in_valid = 1'b1; in_imm = 16'd10; in_tag = 5'd10;
    step();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_tag !== 5'd10 || out_imm !== 32'd10) begin
      n_fail++; $display("FAIL after_flush_beat: got v=%b tag=%0d imm=%h expected v=1 tag=10 imm=a", out_valid, out_tag, out_imm); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL after_flush_drain: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd1; in_imm = 16'h0042; in_tag = 5'd6;
    step();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_tag !== 5'd6) begin
      n_fail++; $display("FAIL areset_pre: got v=%b tag=%0d expected v=1 tag=6", out_valid, out_tag); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_imm !== 32'h0 || out_tag !== 5'h0) begin
      n_fail++; $display("FAIL areset_immediate: got v=%b rdy=%b imm=%h tag=%0d expected all 0", out_valid, in_ready, out_imm, out_tag); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_no_replay cyc%0d: got v=%b tag=%0d expected v=0", i, out_valid, out_tag); end
      step();
    end
  endtask

  task automatic test_random;
    beat_t q[$];
    beat_t exp_b;
    beat_t stall_b;
    logic  stall_prev;
    int    sent;
    int    got;
    int    cyc;
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; stall_b = '0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      if (stall_prev) begin
        n_tests++; if (out_valid !== 1'b1 || {out_imm, out_tag, out_err} !== stall_b) begin
          n_fail++; $display("FAIL rnd_stall cyc%0d: got v=%b imm=%h tag=%0d err=%b expected v=1 imm=%h tag=%0d err=%b",
                             cyc, out_valid, out_imm, out_tag, out_err, stall_b.imm, stall_b.tag, stall_b.err); end
      end
      n_tests++; if (out_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid cyc%0d: got %b expected %b", cyc, out_valid, q.size() != 0); end
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      in_imm    = 16'($urandom);
      in_mode   = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready && q.size() != 0) begin
        exp_b = q.pop_front();
        got++;
        n_tests++; if ({out_imm, out_tag, out_err} !== exp_b) begin
          n_fail++; $display("FAIL rnd_beat%0d: got imm=%h tag=%0d err=%b expected imm=%h tag=%0d err=%b",
                             got, out_imm, out_tag, out_err, exp_b.imm, exp_b.tag, exp_b.err); end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_imm, in_mode, in_tag));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      stall_b    = {out_imm, out_tag, out_err};
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_tests++; if (got != 100 || q.size() != 0) begin
      n_fail++; $display("FAIL rnd_complete: got delivered=%0d pending=%0d expected delivered=100 pending=0", got, q.size()); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
